// File: rtl/gray_updown_counter_if.sv
// Control and status bundle for the Gray up/down counter.
// The master drives the count controls and the slave returns the registered count state.
interface gray_updown_counter_if #(
   parameter int WIDTH = 4
);
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_gray;
   logic             en;
   logic             up_dn;
   logic [WIDTH-1:0] gray_out;
   logic [WIDTH-1:0] bin_out;
   logic             at_max;
   logic             at_min;
   logic             wrap_p;
   logic             sat_p;

   modport master (
      output clr, load, load_gray, en, up_dn,
      input  gray_out, bin_out, at_max, at_min, wrap_p, sat_p
   );

   modport slave (
      input  clr, load, load_gray, en, up_dn,
      output gray_out, bin_out, at_max, at_min, wrap_p, sat_p
   );
endinterface

// File: rtl/gray_updown_counter.sv
// Parametrised up/down Gray counter. Binary and Gray state are registered together,
// so gray_out moves by exactly one bit on every step taken through en.
module gray_updown_counter #(
   parameter int WIDTH   = 4,
   parameter bit WRAP_EN = 1'b1
) (
   input logic               clk,
   input logic               rst,
   gray_updown_counter_if.slave bus
);
   localparam logic [WIDTH-1:0] MAX_C  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   logic [WIDTH-1:0] bin_r;
   logic [WIDTH-1:0] gray_r;
   logic             wrap_r;
   logic             sat_r;
   logic             at_max_r;
   logic             at_min_r;

   logic [WIDTH-1:0] next_bin_s;
   logic [WIDTH-1:0] next_gray_s;
   logic             next_wrap_s;
   logic             next_sat_s;

   // Next-state selection: clr over load over en; limits either wrap or saturate.
   always_comb begin
      next_bin_s  = bin_r;
      next_gray_s = gray_r;
      next_wrap_s = 1'b0;
      next_sat_s  = 1'b0;
      if (bus.clr) begin
         next_bin_s  = ZERO_C;
         next_gray_s = ZERO_C;
      end else if (bus.load) begin
         next_bin_s  = gray2bin(bus.load_gray);
         next_gray_s = bus.load_gray;
      end else if (bus.en) begin
         if (bus.up_dn) begin
            if (bin_r == MAX_C) begin
               if (WRAP_EN) begin
                  next_bin_s  = ZERO_C;
                  next_wrap_s = 1'b1;
               end else begin
                  next_sat_s  = 1'b1;
               end
            end else begin
               next_bin_s = bin_r + ONE_C;
            end
         end else begin
            if (bin_r == ZERO_C) begin
               if (WRAP_EN) begin
                  next_bin_s  = MAX_C;
                  next_wrap_s = 1'b1;
               end else begin
                  next_sat_s  = 1'b1;
               end
            end else begin
               next_bin_s = bin_r - ONE_C;
            end
         end
         next_gray_s = bin2gray(next_bin_s);
      end else begin
         next_bin_s  = bin_r;
         next_gray_s = gray_r;
      end
   end

   // State and status registers; limit flags are registered alongside the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         bin_r    <= ZERO_C;
         gray_r   <= ZERO_C;
         wrap_r   <= 1'b0;
         sat_r    <= 1'b0;
         at_max_r <= 1'b0;
         at_min_r <= 1'b1;
      end else begin
         bin_r    <= next_bin_s;
         gray_r   <= next_gray_s;
         wrap_r   <= next_wrap_s;
         sat_r    <= next_sat_s;
         at_max_r <= (next_bin_s == MAX_C);
         at_min_r <= (next_bin_s == ZERO_C);
      end
   end

   assign bus.gray_out = gray_r;
   assign bus.bin_out  = bin_r;
   assign bus.at_max   = at_max_r;
   assign bus.at_min   = at_min_r;
   assign bus.wrap_p   = wrap_r;
   assign bus.sat_p    = sat_r;
endmodule

// File: tb/tb_gray_updown_counter.sv
// Directed plus random bench for three counter instances (4-bit wrap, 4-bit saturate, 8-bit wrap)
// sharing one control stream, each compared against its own reference model through a queue.
module tb_gray_updown_counter;
   typedef struct {
      logic [7:0] gray;
      logic [7:0] bin;
      logic       amax;
      logic       amin;
      logic       wp;
      logic       sp;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       clr;
   logic       load;
   logic [7:0] lg;
   logic       en;
   logic       up;

   int         vectors;
   int         miscompares;
   exp_t       q[$];
   logic [7:0] m_bin[3];
   int         m_w[3];
   bit         m_wrap[3];
   logic [3:0] gseq[17];

   gray_updown_counter_if #(.WIDTH(4)) ifa ();
   gray_updown_counter_if #(.WIDTH(4)) ifb ();
   gray_updown_counter_if #(.WIDTH(8)) ifc ();

   assign ifa.clr = clr;  assign ifa.load = load;  assign ifa.load_gray = lg[3:0];
   assign ifa.en  = en;   assign ifa.up_dn = up;
   assign ifb.clr = clr;  assign ifb.load = load;  assign ifb.load_gray = lg[3:0];
   assign ifb.en  = en;   assign ifb.up_dn = up;
   assign ifc.clr = clr;  assign ifc.load = load;  assign ifc.load_gray = lg;
   assign ifc.en  = en;   assign ifc.up_dn = up;

   gray_updown_counter #(.WIDTH(4), .WRAP_EN(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   gray_updown_counter #(.WIDTH(4), .WRAP_EN(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
   gray_updown_counter #(.WIDTH(8), .WRAP_EN(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic get_obs(input int d, output exp_t o);
      case (d)
         0: begin
            o.gray = {4'h0, ifa.gray_out}; o.bin = {4'h0, ifa.bin_out};
            o.amax = ifa.at_max; o.amin = ifa.at_min; o.wp = ifa.wrap_p; o.sp = ifa.sat_p;
         end
         1: begin
            o.gray = {4'h0, ifb.gray_out}; o.bin = {4'h0, ifb.bin_out};
            o.amax = ifb.at_max; o.amin = ifb.at_min; o.wp = ifb.wrap_p; o.sp = ifb.sat_p;
         end
         default: begin
            o.gray = ifc.gray_out; o.bin = ifc.bin_out;
            o.amax = ifc.at_max; o.amin = ifc.at_min; o.wp = ifc.wrap_p; o.sp = ifc.sat_p;
         end
      endcase
   endtask

   // Reference model: advances m_bin[d] from the current controls and returns the expected outputs.
   task automatic predict(input int d, output exp_t e);
      logic [7:0] mx, b, g;
      mx = 8'hFF >> (8 - m_w[d]);
      b  = m_bin[d];
      e.wp = 1'b0;
      e.sp = 1'b0;
      if (rst || clr) begin
         b = 8'h00;
      end else if (load) begin
         g = lg & mx;
         for (int i = 0; i < 8; i++) b[i] = ^(g >> i);
      end else if (en) begin
         if (up) begin
            if (b == mx) begin
               if (m_wrap[d]) begin b = 8'h00; e.wp = 1'b1; end
               else e.sp = 1'b1;
            end else b = b + 8'h01;
         end else begin
            if (b == 8'h00) begin
               if (m_wrap[d]) begin b = mx; e.wp = 1'b1; end
               else e.sp = 1'b1;
            end else b = b - 8'h01;
         end
      end
      m_bin[d] = b;
      e.bin  = b;
      e.gray = b ^ (b >> 1);
      e.amax = (b == mx);
      e.amin = (b == 8'h00);
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: push predictions, take the edge, pop and compare every instance.
   task automatic step(input string name);
      exp_t       e, o;
      logic [7:0] pg[3];
      bit         plain;
      plain = !rst && !clr && !load;
      for (int d = 0; d < 3; d++) begin
         get_obs(d, o);
         pg[d] = o.gray;
         predict(d, e);
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         e = q.pop_front();
         get_obs(d, o);
         check($sformatf("%s d%0d gray", name, d), o.gray, e.gray);
         check($sformatf("%s d%0d bin", name, d), o.bin, e.bin);
         check($sformatf("%s d%0d at_max", name, d), {7'h0, o.amax}, {7'h0, e.amax});
         check($sformatf("%s d%0d at_min", name, d), {7'h0, o.amin}, {7'h0, e.amin});
         check($sformatf("%s d%0d wrap_p", name, d), {7'h0, o.wp}, {7'h0, e.wp});
         check($sformatf("%s d%0d sat_p", name, d), {7'h0, o.sp}, {7'h0, e.sp});
         if (plain) begin
            vectors++;
            assert ($countones(pg[d] ^ o.gray) <= 1) else begin
               miscompares++;
               $error("FAIL %s d%0d hamming: observed %0d bits expected <=1", name, d,
                      $countones(pg[d] ^ o.gray));
            end
         end
      end
   endtask

   initial begin
      exp_t o;
      vectors = 0;
      miscompares = 0;
      m_w    = '{4, 4, 8};
      m_wrap = '{1'b1, 1'b0, 1'b1};
      m_bin  = '{8'h00, 8'h00, 8'h00};
      gseq   = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
      rst = 1'b1; clr = 1'b0; load = 1'b0; lg = 8'h00; en = 1'b0; up = 1'b0;
      #2;

      step("reset0");
      step("reset1");
      rst = 1'b0;

      // Full up sweep on the 4-bit wrapping counter against the known Gray sequence.
      en = 1'b1; up = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         step("t1 up");
         get_obs(0, o);
         check($sformatf("t1 gseq %0d", k), o.gray, {4'h0, gseq[k]});
      end
      check("t1 wrap on last", {7'h0, ifa.wrap_p}, 8'h01);

      en = 1'b0; load = 1'b1; lg = 8'h0C;
      step("t2 load");
      load = 1'b0; en = 1'b1; up = 1'b0;
      step("t2 down");
      step("t2 down");
      check("t2 bin 6", {4'h0, ifa.bin_out}, 8'h06);
      check("t2 gray 5", {4'h0, ifa.gray_out}, 8'h05);

      en = 1'b0; clr = 1'b1;
      step("t3 clr");
      clr = 1'b0; en = 1'b1; up = 1'b0;
      step("t3 down at0");
      step("t3 down at0");
      en = 1'b0; load = 1'b1; lg = 8'h08;
      step("t3 load F");
      load = 1'b0; en = 1'b1; up = 1'b1;
      step("t3 up atmax");
      step("t3 up atmax");

      clr = 1'b1; load = 1'b1; lg = 8'h0B; en = 1'b1;
      step("t4 clr>load");
      clr = 1'b0; lg = 8'h05;
      step("t4 load>en");
      check("t4 loaded bin 6", {4'h0, ifa.bin_out}, 8'h06);
      load = 1'b0;

      clr = 1'b1;
      step("t5 clr");
      clr = 1'b0; en = 1'b1; up = 1'b1;
      for (int k = 0; k < 5; k++) step("t5 up");
      rst = 1'b1;
      step("t5 rst");
      rst = 1'b0;
      step("t5 resume");
      check("t5 bin 1", {4'h0, ifa.bin_out}, 8'h01);

      for (int k = 0; k < 10000; k++) begin
         en = 1'($urandom_range(0, 1));
         up = 1'($urandom_range(0, 1));
         step("t6 rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
